soc_evt_collector: RTL
======================

SOC_EVT_COLLECTOR -- requirements
Module: soc_evt_collector

Interface
REQ-001 SHALL have parameter NB_SRC, default 16, number of SoC peripheral event source lines.
REQ-002 SHALL have parameter EVNT_WIDTH, default 8, width of the emitted event ID; matches the event unit SoC FIFO data width.
REQ-003 SHALL have parameter ID_BASE, default 0, ID emitted for source 0; legal only if ID_BASE+NB_SRC <= 2^EVNT_WIDTH.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port evt_i  input  NB_SRC  event lines; each cycle high on bit k = one event from source k.
REQ-007 SHALL have port evt_mask_i  input  NB_SRC  per-source enable; 0 = events on that source ignored (not pended, not lost).
REQ-008 SHALL have port soc_periph_evt_valid_o  output  1  event ID valid toward the event unit SoC FIFO.
REQ-009 SHALL have port soc_periph_evt_ready_i  input  1  event unit FIFO not full.
REQ-010 SHALL have port soc_periph_evt_data_o  output  EVNT_WIDTH  event ID = ID_BASE + source index.
REQ-011 SHALL have port lost_evt_o  output  1  one-cycle pulse: an event was dropped.
REQ-012 SHALL have port lost_id_o  output  EVNT_WIDTH  ID of the dropped event, valid while lost_evt_o=1.

Function
REQ-013 SHALL keep one pending bit per source; an enabled event at cycle t sets pending[k] at edge end of t.
REQ-014 SHALL select, each cycle, one pending source via round-robin: search starts at index last_grant+1 modulo NB_SRC; last_grant resets to NB_SRC-1 so source 0 has first priority.
REQ-015 SHALL load the output register (valid=1, data=ID of selected source), clear that pending bit, and update last_grant when a source is pending and (valid_o=0 or ready_i=1).
REQ-016 SHALL clear valid_o when valid_o=1, ready_i=1 and no source is pending.
REQ-017 SHALL hold valid_o and data_o stable while valid_o=1 and ready_i=0.
REQ-018 SHALL transfer an event on every cycle with valid_o=1 and ready_i=1; sustained throughput one event per cycle with no bubbles.
REQ-019 SHALL have latency of exactly 2 cycles from evt_i pulse (cycle t) to valid_o=1 (cycle t+2) when idle and uncontended.
REQ-020 SHALL, when evt_i[k] and the grant of source k occur in the same cycle, keep pending[k] set (new event retained, old one emitted).
REQ-021 SHALL, when evt_i[k]=1 with pending[k]=1 not granted that cycle, drop the new event and pulse lost_evt_o with lost_id_o=ID_BASE+k in the next cycle.
REQ-022 SHALL, when several sources lose events in the same cycle, report the lowest index; the others are dropped silently.
REQ-023 SHALL not clear an existing pending bit when evt_mask_i deasserts; masking only blocks new events.
REQ-024 SHALL never drop an event already in the output register; ready_i low backpressures indefinitely.

Reset
REQ-025 SHALL, with rst_ni=0 at a rising edge, clear all pending bits, set valid_o=0, data_o=0, lost_evt_o=0, lost_id_o=0, last_grant=NB_SRC-1.
REQ-026 SHALL discard pending and in-flight events on reset mid-operation, with no output transfer in the cycle after reset release.
REQ-027 SHALL ignore evt_i during cycles where rst_ni=0.

Verification
REQ-028 Single event: mask all 1, ready=1, evt_i[3] pulse at cycle 10 -> valid=1, data=3 at cycle 12 only; no lost pulse.
REQ-029 Round robin: pulse evt_i=0x0013 once, ready=1 -> IDs 0,1,4 on consecutive cycles; then pulse 0x0011 -> 0 then 4 (start after last grant 4 wraps to 0).
REQ-030 Backpressure: ready=0, pulse evt_i[2] -> valid held with data=2 stable; pulse evt_i[2] again -> pended; pulse third time -> lost_evt_o=1, lost_id_o=2 next cycle; ready=1 -> two IDs 2 delivered.
REQ-031 Same-cycle set/grant: source 5 pending and granted in cycle where evt_i[5]=1 -> two IDs 5 delivered, no lost pulse.
REQ-032 Masking and ID_BASE: ID_BASE=32, evt_mask_i[7]=0, pulse evt_i[7] and evt_i[8] -> only data=40 emitted.
REQ-033 Reset mid-flight: three sources pending, valid=1, ready=0, assert rst_ni=0 one cycle -> valid=0, all pending cleared, nothing emitted afterwards.

Source files
------------

// File: rtl/soc_evt_collector.sv
// soc_evt_collector
// Collects single-cycle event pulses from NB_SRC SoC peripheral sources,
// pends one event per source and forwards event IDs (ID_BASE + source index)
// to the event unit SoC FIFO over a valid/ready handshake. Sources are served
// round-robin. A second event arriving while a source is still pending, and
// not being granted in that cycle, is dropped and reported on lost_evt_o.
module soc_evt_collector #(
    parameter int NB_SRC     = 16,
    parameter int EVNT_WIDTH = 8,
    parameter int ID_BASE    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_SRC-1:0]     evt_i,
    input  logic [NB_SRC-1:0]     evt_mask_i,
    output logic                  soc_periph_evt_valid_o,
    input  logic                  soc_periph_evt_ready_i,
    output logic [EVNT_WIDTH-1:0] soc_periph_evt_data_o,
    output logic                  lost_evt_o,
    output logic [EVNT_WIDTH-1:0] lost_id_o
);

    localparam int                    IDX_W    = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam logic [EVNT_WIDTH-1:0] ID_OFS   = EVNT_WIDTH'(ID_BASE);
    localparam logic [IDX_W-1:0]      LAST_RST = IDX_W'(NB_SRC - 1);

    logic [NB_SRC-1:0] pending;
    logic [IDX_W-1:0]  last_grant;

    logic [NB_SRC-1:0] evt_en;
    logic [NB_SRC-1:0] grant_vec;
    logic [NB_SRC-1:0] lost_vec;
    logic              grant_found;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic              lost_found;
    logic [IDX_W-1:0]  lost_idx;
    logic              load;

    // Masked sources are simply invisible: they neither pend nor count as lost.
    assign evt_en = evt_i & evt_mask_i;

    // The output register may take a new ID when empty or when its content is
    // being consumed this cycle; this gives back-to-back transfers.
    assign load = grant_found && (!soc_periph_evt_valid_o || soc_periph_evt_ready_i);

    assign grant_vec = load ? (NB_SRC'(1) << grant_idx) : '0;

    // A granted source accepts a same-cycle event, so it is excluded here.
    assign lost_vec  = evt_en & pending & ~grant_vec;

    // Round-robin pick: first pending source after the last granted one.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= NB_SRC; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NB_SRC);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Lowest-index lost source is the one reported; scanning downward lets it win.
    always_comb begin
        lost_found = |lost_vec;
        lost_idx   = '0;
        for (int k = NB_SRC - 1; k >= 0; k--) begin
            if (lost_vec[k]) begin
                lost_idx = IDX_W'(k);
            end
        end
    end

    // Pending bits: grant clears, a new enabled event sets (set wins).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending    <= '0;
            last_grant <= LAST_RST;
        end else begin
            pending <= (pending & ~grant_vec) | evt_en;
            if (load) begin
                last_grant <= grant_idx;
            end
        end
    end

    // Output register toward the event FIFO; held stable under backpressure.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            soc_periph_evt_valid_o <= 1'b0;
            soc_periph_evt_data_o  <= '0;
        end else if (load) begin
            soc_periph_evt_valid_o <= 1'b1;
            soc_periph_evt_data_o  <= ID_OFS + EVNT_WIDTH'(grant_idx);
        end else if (soc_periph_evt_valid_o && soc_periph_evt_ready_i) begin
            soc_periph_evt_valid_o <= 1'b0;
        end
    end

    // Lost-event report: one-cycle pulse with the ID of the dropped event.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lost_evt_o <= 1'b0;
            lost_id_o  <= '0;
        end else begin
            lost_evt_o <= lost_found;
            if (lost_found) begin
                lost_id_o <= ID_OFS + EVNT_WIDTH'(lost_idx);
            end
        end
    end

endmodule
